// File: rtl/fp_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter_if
// Purpose  : FP writeback arbitration bus: per-unit result requests, one-hot
//            grants and the registered single-result output handshake.
// Revision : 1.0
// ============================================================================
interface fp_wb_arbiter_if #(
    parameter int NUM_UNITS = 3,
    parameter int DATA_W    = 34,
    parameter int ID_W      = 3
);
    localparam int c_UNIT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]        unit_done;
    logic [NUM_UNITS*DATA_W-1:0] unit_rd;
    logic [NUM_UNITS*ID_W-1:0]   unit_id;
    logic [NUM_UNITS-1:0]        unit_ack;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_rd;
    logic [ID_W-1:0]             out_id;
    logic [c_UNIT_W-1:0]         out_unit;
    logic                        out_ack;

    // Units and the writeback consumer side
    modport master (
        output unit_done, unit_rd, unit_id, out_ack,
        input  unit_ack, out_valid, out_rd, out_id, out_unit
    );

    // Arbiter side
    modport slave (
        input  unit_done, unit_rd, unit_id, out_ack,
        output unit_ack, out_valid, out_rd, out_id, out_unit
    );
endinterface
`default_nettype wire

// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter
// Purpose  : Round-robin arbiter sharing the FP register-file writeback port
//            between NUM_UNITS units through a one-entry output register.
//            Optional macro FP_WB_MAC_PRIORITY_EN: unit 0 (MAC) has priority,
//            bounded by a starvation counter.
// Revision : 1.0
// ============================================================================
module fp_wb_arbiter #(
    parameter int NUM_UNITS = 3,
    parameter int DATA_W    = 34,
    parameter int ID_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    fp_wb_arbiter_if.slave     wb
);
    localparam int                  c_UNIT_W = $clog2(NUM_UNITS);
    localparam logic [c_UNIT_W-1:0] c_LAST   = c_UNIT_W'(NUM_UNITS - 1);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_rd;
    logic [ID_W-1:0]       r_id;
    logic [c_UNIT_W-1:0]   r_unit;
    logic [c_UNIT_W-1:0]   r_rr_ptr;

    logic                  w_can_load;
    logic [NUM_UNITS-1:0]  w_req_mask;
    logic                  w_rr_found;
    logic [c_UNIT_W-1:0]   w_rr_idx;
    logic                  w_grant_any;
    logic [c_UNIT_W-1:0]   w_grant_idx;
    logic                  w_load;
    logic [NUM_UNITS-1:0]  w_ack;
    logic                  w_ptr_update;

    // Output register refills in the same cycle it drains.
    assign w_can_load = !r_valid || wb.out_ack;

`ifdef FP_WB_MAC_PRIORITY_EN
    localparam logic [2:0] c_STARVE_LIMIT = 3'd4;

    logic [2:0] r_starve;
    logic       w_others_req;
    logic       w_force_rr;

    assign w_others_req = |wb.unit_done[NUM_UNITS-1:1];
    // Once unit 0 has won the limit times in a row against waiting units,
    // hide it for one grant so the others cannot starve.
    assign w_force_rr   = (r_starve >= c_STARVE_LIMIT) && w_others_req;

    always_comb begin
        w_req_mask = wb.unit_done;
        if (w_force_rr) begin
            w_req_mask[0] = 1'b0;
        end
    end

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (!w_force_rr && wb.unit_done[0]) begin
            w_grant_any = 1'b1;
            w_grant_idx = '0;
        end else if (w_rr_found) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_rr_idx;
        end
    end

    assign w_ptr_update = w_load && (w_grant_idx != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_load) begin
            if (w_grant_idx != '0) begin
                r_starve <= '0;
            end else if (w_others_req && (r_starve < c_STARVE_LIMIT)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end
`else
    assign w_req_mask   = wb.unit_done;
    assign w_grant_any  = w_rr_found;
    assign w_grant_idx  = w_rr_idx;
    assign w_ptr_update = w_load;
`endif

    // First requesting unit after the pointer, wrapping modulo NUM_UNITS.
    always_comb begin
        logic [c_UNIT_W-1:0] v_cand;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        v_cand     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            v_cand = c_UNIT_W'((int'(r_rr_ptr) + 1 + k) % NUM_UNITS);
            if (!w_rr_found && w_req_mask[v_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = v_cand;
            end
        end
    end

    assign w_load = w_grant_any && w_can_load && !rst;

    always_comb begin
        w_ack = '0;
        if (w_load) begin
            w_ack[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_id    <= '0;
            r_unit  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_rd    <= wb.unit_rd[int'(w_grant_idx)*DATA_W +: DATA_W];
            r_id    <= wb.unit_id[int'(w_grant_idx)*ID_W +: ID_W];
            r_unit  <= w_grant_idx;
        end else if (wb.out_ack) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= c_LAST;
        end else if (w_ptr_update) begin
            r_rr_ptr <= w_grant_idx;
        end
    end

    assign wb.unit_ack  = w_ack;
    assign wb.out_valid = r_valid;
    assign wb.out_rd    = r_rd;
    assign wb.out_id    = r_id;
    assign wb.out_unit  = r_unit;

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) $onehot0(wb.unit_ack));
    a_ack_done:   assert property (@(posedge clk) (wb.unit_ack & ~wb.unit_done) == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_wb_arbiter
// Purpose  : Scoreboard bench for fp_wb_arbiter: directed scenarios plus
//            randomized traffic checked against a behavioural grant model.
// Revision : 1.0
// ============================================================================
module tb_fp_wb_arbiter;
    localparam int N  = 3;
    localparam int DW = 34;
    localparam int IW = 3;
    localparam int UW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] rd;
        logic [IW-1:0] id;
        logic [UW-1:0] unit;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_wb_arbiter_if #(.NUM_UNITS(N), .DATA_W(DW), .ID_W(IW)) bus ();

    fp_wb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    item_t         sb_q[$];
    int            grant_log[$];
    logic          pend [N];
    logic          acked[N];
    logic [DW-1:0] u_rd [N];
    logic [IW-1:0] u_id [N];
    int            req_pct = 0;
    int            ack_pct = 100;
    logic          rst_req = 1'b1;

    // Reference model state
    logic m_valid = 1'b0;
    int   m_ptr   = N - 1;
    int   m_starve = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] done, input logic ack_in);
        logic [N-1:0] req;
        int           others;
        req = done;
        if (m_valid && !ack_in) return -1;
`ifdef FP_WB_MAC_PRIORITY_EN
        others = 0;
        for (int u = 1; u < N; u++) if (done[u]) others = 1;
        if (m_starve >= 4 && others != 0) req[0] = 1'b0;
        else if (done[0]) return 0;
`else
        others = 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1 + others * 0;
    endfunction

    task automatic load_unit(input int i, input logic [DW-1:0] rd, input logic [IW-1:0] id);
        pend[i] = 1'b1;
        u_rd[i] = rd;
        u_id[i] = id;
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge.
    task automatic step();
        logic [N-1:0] done;
        logic [N-1:0] exp_ack;
        int           g;
        @(posedge clk);
        #1;
        rst = rst_req;
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                pend[i]  = 1'b0;
                acked[i] = 1'b0;
            end else if (!pend[i] && ($urandom_range(99) < req_pct)) begin
                load_unit(i, {2'($urandom_range(3)), 32'($urandom)}, IW'($urandom));
            end
            done[i] = pend[i];
            bus.unit_rd[i*DW +: DW] = u_rd[i];
            bus.unit_id[i*IW +: IW] = u_id[i];
        end
        bus.unit_done = done;
        bus.out_ack   = ($urandom_range(99) < ack_pct);
        @(negedge clk);
        g       = rst ? -1 : model_grant(done, bus.out_ack);
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        check("unit_ack", 64'(bus.unit_ack), 64'(exp_ack));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (rst) begin
            m_valid  = 1'b0;
            m_ptr    = N - 1;
            m_starve = 0;
            sb_q.delete();
        end else if (g >= 0) begin
            sb_q.push_back('{rd: u_rd[g], id: u_id[g], unit: UW'(g)});
            grant_log.push_back(g);
            acked[g] = 1'b1;
            m_valid  = 1'b1;
`ifdef FP_WB_MAC_PRIORITY_EN
            if (g != 0) begin
                m_ptr    = g;
                m_starve = 0;
            end else if ((done >> 1) != '0) begin
                m_starve++;
            end
`else
            m_ptr = g;
`endif
        end else if (bus.out_ack) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: every consumed output must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL out_unexpected: got unit %0d with empty scoreboard", bus.out_unit);
            end else begin
                item_t it;
                it = sb_q.pop_front();
                check("out_rd", 64'(bus.out_rd), 64'(it.rd));
                check("out_id", 64'(bus.out_id), 64'(it.id));
                check("out_unit", 64'(bus.out_unit), 64'(it.unit));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; acked[i] = 1'b0; u_rd[i] = '0; u_id[i] = '0;
        end
        bus.unit_done = '0;
        bus.unit_rd   = '0;
        bus.unit_id   = '0;
        bus.out_ack   = 1'b0;

        // Reset state
        rst_req = 1'b1;
        step();
        step();
        check("rst_out_rd", 64'(bus.out_rd), 64'd0);
        check("rst_out_id", 64'(bus.out_id), 64'd0);
        check("rst_out_unit", 64'(bus.out_unit), 64'd0);
        rst_req = 1'b0;

        // Single request from unit 1
        load_unit(1, 34'h0_3F800000, 3'd5);
        step();
        check("single_grant", 64'(grant_log[$]), 64'd1);
        step();
        repeat (3) step();

        // All units requesting with the consumer always ready, from reset
        req_pct = 100;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        grant_log.delete();
        repeat (6) step();
`ifndef FP_WB_MAC_PRIORITY_EN
        for (int k = 0; k < 6; k++) check("rr_order", 64'(grant_log[k]), 64'(k % N));
`endif

        // Drain everything
        req_pct = 0;
        repeat (6) step();

        // Backpressure: output held while units 0 and 2 wait
        ack_pct = 0;
        load_unit(1, 34'h1_00000011, 3'd1);
        step();
        load_unit(0, 34'h2_12345678, 3'd2);
        load_unit(2, 34'h0_CAFEF00D, 3'd3);
        repeat (3) step();
        ack_pct = 100;
        step();
`ifndef FP_WB_MAC_PRIORITY_EN
        check("bp_next_grant", 64'(grant_log[$]), 64'd2);
`endif
        step();
`ifndef FP_WB_MAC_PRIORITY_EN
        check("bp_wrap_grant", 64'(grant_log[$]), 64'd0);
`endif
        repeat (4) step();

        // Wrap-around after a unit-2 grant
        load_unit(2, 34'h0_00000022, 3'd4);
        step();
        step();
        load_unit(0, 34'h0_00000100, 3'd6);
        load_unit(2, 34'h0_00000102, 3'd7);
        step();
        check("wrap_first", 64'(grant_log[$]), 64'd0);
        step();
        step();
        check("wrap_second", 64'(grant_log[$]), 64'd2);
        repeat (3) step();

        // Reset while the output register is full and unit 1 waits
        ack_pct = 0;
        load_unit(0, 34'h3_00000A00, 3'd1);
        step();
        load_unit(1, 34'h0_00000B01, 3'd2);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        ack_pct = 100;
        load_unit(0, 34'h0_00000C00, 3'd3);
        step();
        check("post_rst_grant", 64'(grant_log[$]), 64'd0);
        repeat (4) step();

        // Randomized traffic with occasional resets
        req_pct = 45;
        ack_pct = 60;
        for (int c = 0; c < 2000; c++) begin
            rst_req = ($urandom_range(199) == 0);
            step();
        end
        rst_req = 1'b0;

        // Final drain: every expected result must have been delivered
        req_pct = 0;
        ack_pct = 100;
        repeat (10) step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
